// File: rtl/jesd_link_watchdog.sv
// rtl/jesd_link_watchdog.sv - JESD204 RX link bring-up, lock supervision and retry controller
module jesd_link_watchdog #(
  parameter int REQ_LEN      = 4,
  parameter int HOLDOFF      = 6000,
  parameter int SYNC_FILTER  = 256,
  parameter int LOSS_LEN     = 16,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int MAX_RETRIES  = 8
) (
  input  logic       m_axi_aclk,
  input  logic       m_axi_aresetn,
  input  logic       enable,
  input  logic       clear_fail,
  input  logic       rx_sync,
  output logic       rx_reset_req,
  output logic       axi_reset_req,
  output logic       link_up,
  output logic       link_failed,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int PH_MAX = (REQ_LEN > HOLDOFF) ? REQ_LEN : HOLDOFF;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TM_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int FL_W   = $clog2(SYNC_FILTER + 1);
  localparam int LS_W   = $clog2(LOSS_LEN + 1);

  localparam logic [PH_W-1:0] REQ_LAST  = PH_W'(REQ_LEN - 1);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLDOFF - 1);
  localparam logic [TM_W-1:0] TM_LAST   = TM_W'(LOCK_TIMEOUT - 1);
  localparam logic [FL_W-1:0] FL_LAST   = FL_W'(SYNC_FILTER - 1);
  localparam logic [LS_W-1:0] LS_LAST   = LS_W'(LOSS_LEN - 1);
  localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_HOLDOFF,
    ST_WAIT_LOCK,
    ST_LOCKED,
    ST_FAILED
  } state_t;

  state_t          state, state_nxt;
  logic            first, first_nxt;
  logic [PH_W-1:0] phase_cnt, phase_nxt;
  logic [TM_W-1:0] lock_tmr, lock_tmr_nxt;
  logic [FL_W-1:0] filt_cnt, filt_nxt;
  logic [LS_W-1:0] lost_cnt, lost_nxt;
  logic [3:0]      retry_nxt;
  logic [7:0]      loss_nxt;
  logic            sync_meta, sync_s;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= rx_sync;
      sync_s    <= sync_meta;
    end
  end

  // Each counter only runs to its last value and is cleared on entry, so none can wrap.
  always_comb begin
    state_nxt    = state;
    first_nxt    = first;
    phase_nxt    = phase_cnt;
    lock_tmr_nxt = lock_tmr;
    filt_nxt     = filt_cnt;
    lost_nxt     = lost_cnt;
    retry_nxt    = retry_count;
    loss_nxt     = loss_count;
    if (!enable) begin
      state_nxt = ST_IDLE;
      first_nxt = 1'b1;
      retry_nxt = 4'd0;
    end else if (state == ST_FAILED && clear_fail) begin
      state_nxt = ST_IDLE;
      first_nxt = 1'b1;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_REQUEST;
          phase_nxt = '0;
        end
        ST_REQUEST: begin
          if (phase_cnt == REQ_LAST) begin
            state_nxt = ST_HOLDOFF;
            first_nxt = 1'b0;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase_cnt + PH_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (phase_cnt == HOLD_LAST) begin
            state_nxt    = ST_WAIT_LOCK;
            lock_tmr_nxt = '0;
            filt_nxt     = '0;
          end else begin
            phase_nxt = phase_cnt + PH_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // A completed filter run beats a timeout landing on the same edge.
          if (sync_s && filt_cnt == FL_LAST) begin
            state_nxt = ST_LOCKED;
            retry_nxt = 4'd0;
            lost_nxt  = '0;
          end else if (lock_tmr == TM_LAST) begin
            if (retry_count == RETRY_MAX) begin
              state_nxt = ST_FAILED;
            end else begin
              state_nxt = ST_REQUEST;
              retry_nxt = retry_count + 4'd1;
              phase_nxt = '0;
            end
          end else begin
            lock_tmr_nxt = lock_tmr + TM_W'(1);
            filt_nxt     = sync_s ? filt_cnt + FL_W'(1) : '0;
          end
        end
        ST_LOCKED: begin
          if (!sync_s && lost_cnt == LS_LAST) begin
            state_nxt = ST_REQUEST;
            retry_nxt = 4'd0;
            phase_nxt = '0;
            if (loss_count != 8'hFF) begin
              loss_nxt = loss_count + 8'd1;
            end
          end else begin
            lost_nxt = sync_s ? '0 : lost_cnt + LS_W'(1);
          end
        end
        ST_FAILED: begin
          state_nxt = ST_FAILED;
        end
        default: begin
          state_nxt = ST_IDLE;
          first_nxt = 1'b1;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= ST_IDLE;
      first         <= 1'b1;
      phase_cnt     <= '0;
      lock_tmr      <= '0;
      filt_cnt      <= '0;
      lost_cnt      <= '0;
      retry_count   <= 4'd0;
      loss_count    <= 8'd0;
      rx_reset_req  <= 1'b0;
      axi_reset_req <= 1'b0;
      link_up       <= 1'b0;
      link_failed   <= 1'b0;
    end else begin
      state         <= state_nxt;
      first         <= first_nxt;
      phase_cnt     <= phase_nxt;
      lock_tmr      <= lock_tmr_nxt;
      filt_cnt      <= filt_nxt;
      lost_cnt      <= lost_nxt;
      retry_count   <= retry_nxt;
      loss_count    <= loss_nxt;
      rx_reset_req  <= (state_nxt == ST_REQUEST);
      axi_reset_req <= (state_nxt == ST_REQUEST) && first_nxt;
      link_up       <= (state_nxt == ST_LOCKED);
      link_failed   <= (state_nxt == ST_FAILED);
    end
  end

endmodule
